nes_pad_responder: RTL and testbench

Controller-side responder for the NES serial joypad protocol. It debounces eight onboard buttons and presents them to a console-side reader, such as the NES core or an external console port, as a 4021-style shift register. The reader drives strobe and clock; this block drives data. It sits between the board button pins and the `joy_strobe`/`joy_clock`/`joy_data` nets, in place of a physical pad.

---
 rtl/nes_pad_responder.sv | 130 +++++++++++++
 tb/tb_nes_pad_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_responder.sv
// nes_pad_responder: debounced 8-button pad answering a NES-style strobe/clock reader as a 4021 shift register
//
// Ports:
//   clock      system clock
//   reset      asynchronous active-high reset
//   btn_raw    raw buttons {right,left,down,up,start,select,b,a}, active-high, asynchronous
//   turbo_a    autofire request for A (PAD_TURBO_EN builds only)
//   turbo_b    autofire request for B (PAD_TURBO_EN builds only)
//   joy_strobe reader latch, active-high, asynchronous
//   joy_clock  reader shift clock, asynchronous; shifting happens on its falling edge
//   joy_data   serial data to the reader, active-low
//   buttons    debounced button state with opposing directions cancelled
//   read_count shifts since the last load, saturating at 8
//
// Optional feature: define PAD_TURBO_EN to build the turbo phase counter that
// ORs a square wave into the A/B bits of the value loaded into the shift register.
module nes_pad_responder #(
    parameter int DEBOUNCE_CYCLES = 21477,
    parameter int TURBO_DIV       = 1789772
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] btn_raw,
    input  logic       turbo_a,
    input  logic       turbo_b,
    input  logic       joy_strobe,
    input  logic       joy_clock,
    output logic       joy_data,
    output logic [7:0] buttons,
    output logic [3:0] read_count
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);

    logic [7:0]    btn_s1_q, btn_s2_q;
    logic          strobe_s1_q, strobe_s2_q;
    logic          clk_s1_q, clk_s2_q, clk_s3_q;
    logic [DW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    logic [7:0]    prev_q, prev_d;
    logic [7:0]    stable_q, stable_d;
    logic [7:0]    sr_q, sr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    load_val;
    logic          clk_fall;
    logic          ud, lr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_s1_q    <= '0;
            btn_s2_q    <= '0;
            strobe_s1_q <= 1'b0;
            strobe_s2_q <= 1'b0;
            clk_s1_q    <= 1'b0;
            clk_s2_q    <= 1'b0;
            clk_s3_q    <= 1'b0;
            tick_cnt_q  <= '0;
            prev_q      <= '0;
            stable_q    <= '0;
            sr_q        <= '0;
            cnt_q       <= '0;
        end else begin
            btn_s1_q    <= btn_raw;
            btn_s2_q    <= btn_s1_q;
            strobe_s1_q <= joy_strobe;
            strobe_s2_q <= strobe_s1_q;
            clk_s1_q    <= joy_clock;
            clk_s2_q    <= clk_s1_q;
            clk_s3_q    <= clk_s2_q;
            tick_cnt_q  <= tick_cnt_d;
            prev_q      <= prev_d;
            stable_q    <= stable_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
        end
    end

    // A bit only moves when two consecutive samples one tick apart agree.
    always_comb begin
        tick       = tick_cnt_q == DW'(DEBOUNCE_CYCLES - 1);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        prev_d     = tick ? btn_s2_q : prev_q;
        stable_d   = tick ? ((btn_s2_q & ~(btn_s2_q ^ prev_q)) | (stable_q & (btn_s2_q ^ prev_q))) : stable_q;
    end

    // Opposing directions pressed together report neither.
    always_comb begin
        ud      = stable_q[4] & stable_q[5];
        lr      = stable_q[6] & stable_q[7];
        buttons = stable_q & ~{lr, lr, ud, ud, 4'b0000};
    end

`ifdef PAD_TURBO_EN
    localparam int TW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

    logic [TW-1:0] turbo_cnt_q, turbo_cnt_d;
    logic          phase_q, phase_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            turbo_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            turbo_cnt_q <= turbo_cnt_d;
            phase_q     <= phase_d;
        end
    end

    always_comb begin
        turbo_cnt_d = (turbo_cnt_q == TW'(TURBO_DIV - 1)) ? '0 : turbo_cnt_q + 1'b1;
        phase_d     = (turbo_cnt_q == TW'(TURBO_DIV - 1)) ? ~phase_q : phase_q;
        load_val    = buttons | {6'b000000, turbo_b & phase_q, turbo_a & phase_q};
    end
`else
    logic unused_turbo;

    assign unused_turbo = turbo_a ^ turbo_b;
    assign load_val     = buttons;
`endif

    // Load dominates: a shift-clock edge while strobe is high is dropped.
    // Shifting fills with 1s so reads past the 8th bit return "pressed" like an official pad.
    always_comb begin
        clk_fall = clk_s3_q & ~clk_s2_q;
        sr_d     = strobe_s2_q ? load_val : clk_fall ? {1'b1, sr_q[7:1]} : sr_q;
        cnt_d    = strobe_s2_q ? 4'd0 : (clk_fall && cnt_q != 4'd8) ? cnt_q + 4'd1 : cnt_q;
    end

    assign joy_data   = ~sr_q[0];
    assign read_count = cnt_q;
endmodule

// File: tb/tb_nes_pad_responder.sv
// tb_nes_pad_responder: table-driven and scoreboard checks of debounce, masking, serial reads, reset and turbo
module tb_nes_pad_responder;
    localparam int DEB  = 1000;
    localparam int TDIV = 50;

    typedef struct {
        logic       data;
        logic [3:0] cnt;
    } rd_t;

    typedef struct {
        logic [7:0] btn;
        logic [7:0] exp;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] btn_raw = 8'h00;
    logic       turbo_a = 1'b0;
    logic       turbo_b = 1'b0;
    logic       joy_strobe = 1'b0;
    logic       joy_clock = 1'b0;
    logic       joy_data;
    logic [7:0] buttons;
    logic [3:0] read_count;
    int         errors = 0;
    int         checks = 0;
    int         cyc;
    rd_t        exp_q[$];
    vec_t       vecs[10];

    nes_pad_responder #(.DEBOUNCE_CYCLES(DEB), .TURBO_DIV(TDIV)) dut (
        .clock(clock),
        .reset(reset),
        .btn_raw(btn_raw),
        .turbo_a(turbo_a),
        .turbo_b(turbo_b),
        .joy_strobe(joy_strobe),
        .joy_clock(joy_clock),
        .joy_data(joy_data),
        .buttons(buttons),
        .read_count(read_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name);
        rd_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no scoreboard entry expected one", name);
            return;
        end
        e = exp_q.pop_front();
        chk({name, " data"}, {7'b0, joy_data}, {7'b0, e.data});
        chk({name, " count"}, {4'b0, read_count}, {4'b0, e.cnt});
    endtask

    // Strobe, then n shift-clock pulses; each bit's expectation is queued as the pulse is driven.
    task automatic read_pad(input logic [7:0] ld, input int n, input string name);
        logic [7:0] t;
        joy_strobe = 1'b1;
        exp_q.push_back('{~ld[0], 4'd0});
        wait_n(4);
        joy_strobe = 1'b0;
        wait_n(4);
        pop_check(name);
        for (int k = 1; k <= n; k++) begin
            t = ld >> k;
            joy_clock = 1'b1;
            exp_q.push_back('{(k < 8) ? ~t[0] : 1'b0, (k > 8) ? 4'd8 : 4'(k)});
            wait_n(3);
            joy_clock = 1'b0;
            wait_n(4);
            pop_check(name);
        end
    endtask

    initial begin
        int n;
        logic ph;
        vecs[0] = '{8'h01, 8'h01};
        vecs[1] = '{8'h30, 8'h00};
        vecs[2] = '{8'h10, 8'h10};
        vecs[3] = '{8'hC0, 8'h00};
        vecs[4] = '{8'hA5, 8'hA5};
        vecs[5] = '{8'h5A, 8'h5A};
        vecs[6] = '{8'hF3, 8'h03};
        vecs[7] = '{8'h71, 8'h41};
        vecs[8] = '{8'hFF, 8'h0F};
        vecs[9] = '{8'h80, 8'h80};

        wait_n(3);
        chk("reset joy_data", {7'b0, joy_data}, 8'h01);
        chk("reset buttons", buttons, 8'h00);
        chk("reset read_count", {4'b0, read_count}, 8'h00);
        reset = 1'b0;
        wait_n(2);

        for (int i = 0; i < 10; i++) begin
            btn_raw = vecs[i].btn;
            wait_n(2 * DEB + 10);
            chk($sformatf("buttons vec%0d", i), buttons, vecs[i].exp);
            read_pad(vecs[i].exp, 9, $sformatf("read vec%0d", i));
        end

        joy_strobe = 1'b1;
        wait_n(4);
        for (int i = 0; i < 4; i++) begin
            joy_clock = 1'b1;
            wait_n(3);
            joy_clock = 1'b0;
            wait_n(4);
            chk("strobe-high count", {4'b0, read_count}, 8'h00);
            chk("strobe-high data", {7'b0, joy_data}, 8'h01);
        end
        joy_strobe = 1'b0;
        wait_n(4);

        btn_raw = 8'h00;
        wait_n(2 * DEB + 10);
        chk("glitch baseline", buttons, 8'h00);
        for (int i = 0; i < 30; i++) begin
            btn_raw[4] = ~btn_raw[4];
            wait_n(200);
            chk("glitch bit4", {7'b0, buttons[4]}, 8'h00);
        end
        btn_raw = 8'h10;
        wait_n(2 * DEB + 4);
        chk("held bit4", buttons, 8'h10);

        read_pad(8'h10, 3, "pre-reset");
        reset = 1'b1;
        #1;
        chk("mid-read reset data", {7'b0, joy_data}, 8'h01);
        chk("mid-read reset count", {4'b0, read_count}, 8'h00);
        chk("mid-read reset buttons", buttons, 8'h00);
        wait_n(3);
        reset = 1'b0;
        wait_n(2 * DEB + 10);
        chk("post-reset buttons", buttons, 8'h10);
        read_pad(8'h10, 9, "post-reset");

        btn_raw = 8'h00;
        wait_n(2 * DEB + 10);
        chk("turbo baseline", buttons, 8'h00);
        turbo_a = 1'b1;
        joy_strobe = 1'b1;
        wait_n(4);
        for (int i = 0; i < 300; i++) begin
            wait_n(1);
            if (i % 7 == 0) begin
                n = cyc;
                ph = ((n - 1) / TDIV) % 2 == 1;
`ifdef PAD_TURBO_EN
                if ((n - 1) % TDIV >= 5 && (n - 1) % TDIV <= 45)
                    chk("turbo A data", {7'b0, joy_data}, {7'b0, ~ph});
`else
                chk("turbo A data", {7'b0, joy_data}, {7'b0, ph | 1'b1});
`endif
            end
        end
        chk("turbo buttons", buttons, 8'h00);
        joy_strobe = 1'b0;
        turbo_a = 1'b0;
        wait_n(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
